// File: rtl/osd_regaccess_pkg.sv
// Shared types for the register-access path between the status/control
// interface and the local register routers.
package osd_regaccess_pkg;

  localparam logic [1:0] REQ_SIZE_16 = 2'b01;
  localparam logic [1:0] REQ_SIZE_32 = 2'b10;
  localparam logic [1:0] REQ_SIZE_64 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2
  } regacc_state_t;

endpackage

// File: rtl/osd_regaccess_decode.sv
// Address window decode: maps a 16-bit register address to a slave index
// and an offset inside that slave's window.
module osd_regaccess_decode #(
  parameter int          NUM_SLAVES = 4,
  parameter logic [15:0] BASE_ADDR  = 16'h0200,
  parameter int          WIN_BITS   = 4
) (
  input  logic [15:0]         addr,
  output logic                hit,
  output logic [2:0]          idx,
  output logic [WIN_BITS-1:0] offset
);

  localparam logic [15:0] NUM_SLAVES_W = 16'(NUM_SLAVES);

  logic [15:0] diff;
  logic [15:0] idx_full;

  // Unsigned compare guards the subtraction, so addresses below the base never wrap into a window.
  always_comb begin
    diff     = addr - BASE_ADDR;
    idx_full = diff >> WIN_BITS;
    hit      = (addr >= BASE_ADDR) && (idx_full < NUM_SLAVES_W);
    idx      = idx_full[2:0];
    offset   = addr[WIN_BITS-1:0];
  end

endmodule

// File: rtl/osd_regaccess_router.sv
// Routes the upstream register request to one of NUM_SLAVES register banks,
// with per-access timeout and exactly one ack/err per accepted request.
module osd_regaccess_router
  import osd_regaccess_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [15:0] BASE_ADDR  = 16'h0200,
  parameter int          WIN_BITS   = 4,
  parameter int          TIMEOUT    = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_request,
  input  logic                     reg_write,
  input  logic [15:0]              reg_addr,
  input  logic [1:0]               reg_size,
  input  logic [15:0]              reg_wdata,
  output logic                     reg_ack,
  output logic                     reg_err,
  output logic [15:0]              reg_rdata,
  output logic [NUM_SLAVES-1:0]    slv_request,
  output logic                     slv_write,
  output logic [WIN_BITS-1:0]      slv_addr,
  output logic [15:0]              slv_wdata,
  input  logic [NUM_SLAVES-1:0]    slv_ack,
  input  logic [NUM_SLAVES-1:0]    slv_err,
  input  logic [16*NUM_SLAVES-1:0] slv_rdata,
  output logic                     busy
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  regacc_state_t state, state_n;
  logic [15:0]         cnt, cnt_n;
  logic                err_q, err_n;
  logic [2:0]          sel;
  logic [15:0]         rdata_q;
  logic                load, cap;

  logic                dec_hit;
  logic [2:0]          dec_idx;
  logic [WIN_BITS-1:0] dec_offset;

  logic [NUM_SLAVES-1:0] sel_onehot;
  logic                  sel_ack, sel_err;
  logic [15:0]           sel_rdata;

  osd_regaccess_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .BASE_ADDR  (BASE_ADDR),
    .WIN_BITS   (WIN_BITS)
  ) u_decode (
    .addr   (reg_addr),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .offset (dec_offset)
  );

  // Selected-slave view of the downstream handshake
  always_comb begin
    sel_onehot = NUM_SLAVES'(1) << sel;
    sel_ack    = |(slv_ack & sel_onehot);
    sel_err    = |(slv_err & sel_onehot);
    sel_rdata  = 16'h0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == 3'(i)) sel_rdata = slv_rdata[16*i +: 16];
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = err_q;
    load    = 1'b0;
    cap     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (reg_request) begin
          load = 1'b1;
          if (!dec_hit || reg_size != REQ_SIZE_16) begin
            err_n   = 1'b1;
            state_n = ST_RESP;
          end else begin
            err_n   = 1'b0;
            cnt_n   = 16'h0;
            state_n = ST_FWD;
          end
        end
      end
      ST_FWD: begin
        // Upstream abort takes priority over anything the slave does this cycle.
        if (!reg_request) begin
          state_n = ST_IDLE;
        end else if (sel_err) begin
          err_n   = 1'b1;
          state_n = ST_RESP;
        end else if (sel_ack) begin
          err_n   = 1'b0;
          cap     = 1'b1;
          state_n = ST_RESP;
        end else if (cnt == CNT_LAST) begin
          err_n   = 1'b1;
          state_n = ST_RESP;
        end else begin
          cnt_n = cnt + 16'h1;
        end
      end
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 16'h0;
      err_q     <= 1'b0;
      sel       <= 3'h0;
      slv_write <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= 16'h0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      err_q <= err_n;
      if (load) begin
        sel       <= dec_idx;
        slv_write <= reg_write;
        slv_addr  <= dec_offset;
        slv_wdata <= reg_wdata;
      end
    end
  end

  // Captured read data is only visible while gated by RESP, so it needs no reset.
  always_ff @(posedge clk) begin
    if (cap) rdata_q <= sel_rdata;
  end

  always_comb begin
    busy        = (state != ST_IDLE);
    reg_ack     = (state == ST_RESP) && !err_q;
    reg_err     = (state == ST_RESP) && err_q;
    reg_rdata   = (reg_ack && !slv_write) ? rdata_q : 16'h0;
    slv_request = (state == ST_FWD) ? sel_onehot : '0;
  end

endmodule

// File: tb/tb_osd_regaccess_router.sv
// Directed bench for osd_regaccess_router (TIMEOUT shortened to 16).
module tb_osd_regaccess_router;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_request, reg_write;
  logic [15:0] reg_addr, reg_wdata;
  logic [1:0]  reg_size;
  logic        reg_ack, reg_err, slv_write, busy;
  logic [15:0] reg_rdata, slv_wdata;
  logic [3:0]  slv_request, slv_addr, slv_ack, slv_err;
  logic [63:0] slv_rdata;

  int tests = 0;
  int fails = 0;

  osd_regaccess_router #(
    .NUM_SLAVES (4),
    .BASE_ADDR  (16'h0200),
    .WIN_BITS   (4),
    .TIMEOUT    (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reg_request (reg_request),
    .reg_write   (reg_write),
    .reg_addr    (reg_addr),
    .reg_size    (reg_size),
    .reg_wdata   (reg_wdata),
    .reg_ack     (reg_ack),
    .reg_err     (reg_err),
    .reg_rdata   (reg_rdata),
    .slv_request (slv_request),
    .slv_write   (slv_write),
    .slv_addr    (slv_addr),
    .slv_wdata   (slv_wdata),
    .slv_ack     (slv_ack),
    .slv_err     (slv_err),
    .slv_rdata   (slv_rdata),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic w, input logic [1:0] sz,
                       input logic [15:0] wd);
    reg_request = 1'b1;
    reg_write   = w;
    reg_addr    = a;
    reg_size    = sz;
    reg_wdata   = wd;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ack"}, 16'(reg_ack), 16'h0);
    chk({tag, "_err"}, 16'(reg_err), 16'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   16'(reg_ack), 16'h0);
    chk({tag, "_err"},   16'(reg_err), 16'h0);
    chk({tag, "_rdata"}, reg_rdata, 16'h0);
    chk({tag, "_sreq"},  16'(slv_request), 16'h0);
    chk({tag, "_swr"},   16'(slv_write), 16'h0);
    chk({tag, "_saddr"}, 16'(slv_addr), 16'h0);
    chk({tag, "_swd"},   slv_wdata, 16'h0);
    chk({tag, "_busy"},  16'(busy), 16'h0);
  endtask

  initial begin
    rst = 1'b1;
    reg_request = 1'b0; reg_write = 1'b0; reg_addr = 16'h0;
    reg_size = 2'b01; reg_wdata = 16'h0;
    slv_ack = 4'h0; slv_err = 4'h0;
    slv_rdata = {16'h3333, 16'h2222, 16'hBEEF, 16'h1111};
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Test 1: read 0x0213, slave 1 acks in its first FWD cycle
    issue(16'h0213, 1'b0, 2'b01, 16'h0);
    tick();
    chk("t1_sreq", 16'(slv_request), 16'h0002);
    chk("t1_saddr", 16'(slv_addr), 16'h0003);
    chk("t1_busy", 16'(busy), 16'h0001);
    chk_quiet("t1_c1");
    slv_ack = 4'b0010;
    tick();
    slv_ack = 4'h0;
    chk("t1_ack", 16'(reg_ack), 16'h0001);
    chk("t1_err", 16'(reg_err), 16'h0);
    chk("t1_rdata", reg_rdata, 16'hBEEF);
    chk("t1_sreq_off", 16'(slv_request), 16'h0);
    reg_request = 1'b0;
    tick();
    chk_quiet("t1_after");
    chk("t1_idle", 16'(busy), 16'h0);

    // Test 2: write 0x0230 = 0x1234, slave 3 acks in the sixth FWD cycle
    issue(16'h0230, 1'b1, 2'b01, 16'h1234);
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("t2_sreq", 16'(slv_request), 16'h0008);
      chk("t2_swr", 16'(slv_write), 16'h0001);
      chk("t2_swd", slv_wdata, 16'h1234);
      chk("t2_saddr", 16'(slv_addr), 16'h0000);
      chk_quiet("t2_wait");
    end
    slv_ack = 4'b1000;
    tick();
    slv_ack = 4'h0;
    chk("t2_ack", 16'(reg_ack), 16'h0001);
    chk("t2_rdata", reg_rdata, 16'h0);
    reg_request = 1'b0;
    tick();

    // Test 3: misses and bad size give err at cycle 1 without any slave request
    issue(16'h0240, 1'b0, 2'b01, 16'h0);
    tick();
    chk("t3a_err", 16'(reg_err), 16'h0001);
    chk("t3a_ack", 16'(reg_ack), 16'h0);
    chk("t3a_sreq", 16'(slv_request), 16'h0);
    reg_request = 1'b0;
    tick();
    issue(16'h01FF, 1'b0, 2'b01, 16'h0);
    tick();
    chk("t3b_err", 16'(reg_err), 16'h0001);
    chk("t3b_sreq", 16'(slv_request), 16'h0);
    reg_request = 1'b0;
    tick();
    issue(16'h0200, 1'b0, 2'b10, 16'h0);
    tick();
    chk("t3c_err", 16'(reg_err), 16'h0001);
    chk("t3c_sreq", 16'(slv_request), 16'h0);
    reg_request = 1'b0;
    tick();

    // Test 4: slave 0 never answers, timeout after 16 FWD cycles
    issue(16'h0205, 1'b0, 2'b01, 16'h0);
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk("t4_sreq", 16'(slv_request), 16'h0001);
      chk_quiet("t4_wait");
    end
    tick();
    chk("t4_err", 16'(reg_err), 16'h0001);
    chk("t4_ack", 16'(reg_ack), 16'h0);
    chk("t4_sreq_off", 16'(slv_request), 16'h0);
    reg_request = 1'b0;
    tick();
    slv_ack = 4'b0001;
    tick();
    slv_ack = 4'h0;
    chk_quiet("t4_late");
    chk("t4_busy", 16'(busy), 16'h0);

    // Test 5: foreign ack ignored, simultaneous ack+err reports err
    issue(16'h0220, 1'b0, 2'b01, 16'h0);
    tick();
    chk("t5_sreq", 16'(slv_request), 16'h0004);
    slv_ack = 4'b0010;
    tick();
    chk_quiet("t5_foreign");
    chk("t5_sreq_hold", 16'(slv_request), 16'h0004);
    slv_ack = 4'b0100;
    slv_err = 4'b0100;
    tick();
    slv_ack = 4'h0;
    slv_err = 4'h0;
    chk("t5_err", 16'(reg_err), 16'h0001);
    chk("t5_ack", 16'(reg_ack), 16'h0);
    reg_request = 1'b0;
    tick();

    // Test 6a: upstream abort on the third FWD cycle, then a normal read
    issue(16'h0210, 1'b0, 2'b01, 16'h0);
    tick(); tick(); tick();
    chk("t6a_sreq", 16'(slv_request), 16'h0002);
    reg_request = 1'b0;
    tick();
    chk("t6a_sreq_off", 16'(slv_request), 16'h0);
    chk("t6a_busy", 16'(busy), 16'h0);
    chk_quiet("t6a_abort");
    tick();
    chk_quiet("t6a_after");
    issue(16'h0213, 1'b0, 2'b01, 16'h0);
    tick();
    slv_ack = 4'b0010;
    tick();
    slv_ack = 4'h0;
    chk("t6a_next_ack", 16'(reg_ack), 16'h0001);
    chk("t6a_next_rdata", reg_rdata, 16'hBEEF);
    reg_request = 1'b0;
    tick();

    // Test 6b: reset on the third FWD cycle, then a normal read from slave 0
    issue(16'h0230, 1'b1, 2'b01, 16'h5678);
    tick(); tick(); tick();
    chk("t6b_swd", slv_wdata, 16'h5678);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    reg_request = 1'b0;
    chk_all_zero("t6b_rst");
    tick();
    chk_quiet("t6b_after");
    issue(16'h0201, 1'b0, 2'b01, 16'h0);
    tick();
    chk("t6b_next_sreq", 16'(slv_request), 16'h0001);
    chk("t6b_next_saddr", 16'(slv_addr), 16'h0001);
    slv_ack = 4'b0001;
    tick();
    slv_ack = 4'h0;
    chk("t6b_next_ack", 16'(reg_ack), 16'h0001);
    chk("t6b_next_rdata", reg_rdata, 16'h1111);
    reg_request = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/osd_regaccess_router.md
Name: osd_regaccess_router

Overview:
- Controller/router for the external register port of the module status/control interface.
- Takes the single upstream register request (addresses outside the base register range) and steers it to one of NUM_SLAVES register-backed sub-units by address window.
- Sequences the slave handshake, enforces a per-access timeout, and returns exactly one ack or err per accepted request.
- Sits inside a debug module, between the status/control interface and that module's local register banks.

Parameters:
- NUM_SLAVES, 4, number of downstream register slaves (1..8).
- BASE_ADDR, 16'h0200, first register address of slave 0's window.
- WIN_BITS, 4, log2 of the per-slave window size in 16-bit registers.
- TIMEOUT, 256, cycles a forwarded request may wait for a slave before an error is returned (2..65535).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- reg_request  in  1  upstream request; held high until reg_ack or reg_err
- reg_write  in  1  1 = write, 0 = read
- reg_addr  in  16  register address
- reg_size  in  2  access size; 2'b01 = 16 bit
- reg_wdata  in  16  write data
- reg_ack  out  1  one-cycle success strobe
- reg_err  out  1  one-cycle error strobe
- reg_rdata  out  16  read data, valid with reg_ack
- slv_request  out  NUM_SLAVES  one-hot request to the selected slave
- slv_write  out  1  registered copy of reg_write
- slv_addr  out  WIN_BITS  offset within the selected window
- slv_wdata  out  16  registered write data
- slv_ack  in  NUM_SLAVES  per-slave ack
- slv_err  in  NUM_SLAVES  per-slave err
- slv_rdata  in  16*NUM_SLAVES  per-slave read data; slave i occupies bits [16i+15:16i]
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state IDLE. All outputs are 0: reg_ack, reg_err, reg_rdata, slv_request, slv_write, slv_addr, slv_wdata, busy. Timeout counter is 0.

Address decode:
- idx = (reg_addr - BASE_ADDR) >> WIN_BITS.
- Hit when reg_addr >= BASE_ADDR and idx < NUM_SLAVES.
- slv_addr = reg_addr[WIN_BITS-1:0].
- Compare as unsigned 16-bit values; there is no wrap-around at 16'hFFFF.

States:
- IDLE:
  - If reg_request, latch idx, reg_write, slv_addr and reg_wdata.
  - Miss, or reg_size != 2'b01 -> RESP with err=1.
  - Otherwise -> FWD, clearing the timeout counter.
- FWD:
  - slv_request[sel] = 1; all other bits 0.
  - If slv_err[sel]: err=1 -> RESP.
  - Else if slv_ack[sel]: capture slv_rdata[sel] and set err=0 -> RESP.
  - Else if counter == TIMEOUT-1: err=1 -> RESP.
  - Else increment the counter.
  - If reg_request deasserts while in FWD (upstream abort): -> IDLE immediately, with no ack/err.
- RESP:
  - Drive reg_ack = !err and reg_err = err for exactly one cycle.
  - reg_rdata = captured data on a read ack, otherwise 16'h0.
  - Then -> IDLE.
- Upstream drops reg_request on the cycle after the strobe, so IDLE never re-accepts the same request.

Latency:
- Slave acking on its first FWD cycle: request seen at cycle 0, strobe at cycle 2.
- Miss or bad size: strobe at cycle 1.
- Timeout: strobe at cycle TIMEOUT+1.

Boundary conditions:
- slv_ack and slv_err asserted together: err wins.
- Ack/err from a non-selected slave: ignored.
- Late slave ack after an abort or timeout: ignored.
- reg_rdata and reg_ack come from registers; there is no combinational path from slave inputs to upstream outputs.
- slv_write, slv_addr and slv_wdata stay stable for the whole FWD period.
- rst asserted mid-access: next cycle is IDLE with all outputs 0 and no response strobe.

Decomposition:
- Shared package osd_regaccess_pkg holds:
  - REQ_SIZE_16 = 2'b01, REQ_SIZE_32 = 2'b10, REQ_SIZE_64 = 2'b11
  - the state enum type
- The same package is reused by the status/control interface.
- One sub-module, osd_regaccess_decode (combinational): takes reg_addr and outputs hit, idx and offset. It is instantiated once and reused by future routers.
- The timeout counter stays inline.

Test Plan:
1. Read 16'h0213, size 01; slave 1 acks in its first FWD cycle with 16'hBEEF -> slv_request = 4'b0010, slv_addr = 4'h3, reg_ack at cycle 2, reg_rdata = 16'hBEEF.
2. Write 16'h0230 = 16'h1234; slave 3 acks after 5 cycles -> slv_write = 1, slv_wdata = 16'h1234 stable throughout, reg_ack at cycle 7, reg_rdata = 0.
3. Address 16'h0240 (beyond slave 3's window) or 16'h01FF -> no slv_request, reg_err at cycle 1. Same result for 16'h0200 with size 2'b10.
4. TIMEOUT = 16, slave 0 never responds -> slv_request[0] high cycles 1–16, reg_err at cycle 17; a slave ack on cycle 18 is ignored.
5. Slave 2 asserts ack and err in the same cycle -> reg_err only. An ack from slave 1 while slave 2 is selected produces no response.
6. Abort and reset cases:
   - reg_request drops at cycle 3 of FWD -> slv_request = 0 next cycle, no strobe, busy = 0.
   - rst at cycle 3 of FWD -> all outputs 0 next cycle.
   - A following request completes normally after either case.
